// File: rtl/gf2m_mul_serial.sv
// Bit-serial GF(2^M) polynomial-basis multiplier/squarer, MSB-first, one bit per clock.
// One-shot request/response: IN_VALID starts a product, OUT_VALID pulses with the result on C.
module gf2m_mul_serial #(
  parameter int unsigned M    = 163,
  parameter logic [M-1:0] POLY = M'(8'hC9),
  parameter int unsigned CW   = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  input  logic         SQR,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] C,
  output logic         OUT_VALID,
  output logic         BUSY,
  output logic         ERROR
);

  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   ra_q, ra_d;
  logic [M-1:0]   rb_q, rb_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   c_d;
  logic           out_valid_d, busy_d, error_d;
  logic           accept;

  // Multiply by x modulo P(x): shift up and fold the overflow bit back in.
  function automatic logic [M-1:0] shl(input logic [M-1:0] x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY : '0);
  endfunction

  // rb is shifted left each step so its MSB is always the current multiplier bit.
  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    c_d         = C;
    out_valid_d = 1'b0;
    error_d     = 1'b0;
    accept      = IN_VALID && (state_q == IDLE || state_q == DONE);

    case (state_q)
      IDLE: ;
      RUN: begin
        acc_d   = shl(acc_q) ^ (rb_q[M-1] ? ra_q : '0);
        rb_d    = rb_q << 1;
        error_d = IN_VALID;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        c_d         = acc_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      ra_d    = A;
      rb_d    = SQR ? A : B;
      acc_d   = '0;
      cnt_d   = CNT_LAST;
      state_d = RUN;
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      C         <= '0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      C         <= c_d;
      OUT_VALID <= out_valid_d;
      BUSY      <= busy_d;
      ERROR     <= error_d;
    end
  end

endmodule
